// File: rtl/bike_sensor_monitor.sv
// bike_sensor_monitor
//   Synchronises and debounces N_CH contact inputs, drives one LED per channel
//   from the debounced level, emits one-cycle rising-edge pulses, and runs a
//   seat-absence alarm on channel ALARM_CH that drives the buzzer.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   btn_in        raw asynchronous contact inputs, 1 = pressed/occupied
//   ack           synchronous alarm acknowledge (level)
//   BOARD_LEDs    debounced level per channel
//   rise_pulse    one-cycle pulse per accepted debounced 0->1 edge
//   alarm_active  high while the alarm FSM is in ALARM
//   BUZZER        buzzer drive
//
// Build option
//   BUZZER_PWM_EN  when defined, BUZZER is a square wave (half-period TONE_DIV)
//                  while in ALARM; otherwise BUZZER follows alarm_active.

module bike_sensor_monitor #(
  parameter int unsigned N_CH            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned ALARM_CH        = 4,
  parameter int unsigned ALARM_TIMEOUT   = 50000000,
  parameter int unsigned TONE_DIV        = 12500
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  input  logic            ack,
  output logic [N_CH-1:0] BOARD_LEDs,
  output logic [N_CH-1:0] rise_pulse,
  output logic            alarm_active,
  output logic            BUZZER
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TM_W = $clog2(ALARM_TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(ALARM_TIMEOUT - 1);

  // Reject illegal parameter combinations at elaboration time
  if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || ALARM_CH >= N_CH ||
      ALARM_TIMEOUT < 1 || TONE_DIV < 1) begin : g_param_check
    $error("bike_sensor_monitor: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_COUNT = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] stable_q, stable_d;
  logic [N_CH-1:0] stable_dly_q, stable_dly_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [DB_W-1:0] db_cnt_q [N_CH];
  logic [DB_W-1:0] db_cnt_d [N_CH];

  state_t          state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            alarm_q, alarm_d;
  logic            buzzer_q, buzzer_d;
  logic            seat;

  // Synchroniser, debounce counters and rising-edge detect
  always_comb begin
    sync1_d      = btn_in;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    rise_d       = stable_q & ~stable_dly_q;
    for (int i = 0; i < int'(N_CH); i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        // Accept on the DEBOUNCE_CYCLES-th consecutive differing sample
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Seat-absence alarm next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    seat    = stable_q[ALARM_CH];
    unique case (state_q)
      S_IDLE: begin
        if (seat) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!seat) begin
          state_d = S_COUNT;
          timer_d = '0;
        end
      end
      S_COUNT: begin
        if (seat) begin
          state_d = S_ARMED;
        end else if (timer_q == TM_LAST) begin
          state_d = S_ALARM;
        end else begin
          timer_d = timer_q + TM_W'(1);
        end
      end
      S_ALARM: begin
        // Seat re-occupied takes priority over acknowledge
        if (seat) begin
          state_d = S_ARMED;
        end else if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    alarm_d = (state_d == S_ALARM);
  end

`ifdef BUZZER_PWM_EN
  localparam int unsigned TN_W = $clog2(TONE_DIV + 1);
  localparam logic [TN_W-1:0] TN_LAST = TN_W'(TONE_DIV - 1);

  logic [TN_W-1:0] tone_cnt_q, tone_cnt_d;

  // Tone divider: held at zero outside ALARM so the tone starts low on entry
  always_comb begin
    tone_cnt_d = '0;
    buzzer_d   = 1'b0;
    if (state_q == S_ALARM && state_d == S_ALARM) begin
      if (tone_cnt_q == TN_LAST) begin
        tone_cnt_d = '0;
        buzzer_d   = ~buzzer_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TN_W'(1);
        buzzer_d   = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
    end
  end
`else
  // Plain buzzer follows the alarm state
  always_comb begin
    buzzer_d = alarm_d;
  end
`endif

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      rise_q       <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q      <= S_IDLE;
      timer_q      <= '0;
      alarm_q      <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      rise_q       <= rise_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q      <= state_d;
      timer_q      <= timer_d;
      alarm_q      <= alarm_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign BOARD_LEDs   = stable_q;
  assign rise_pulse   = rise_q;
  assign alarm_active = alarm_q;
  assign BUZZER       = buzzer_q;

endmodule

// File: tb/tb_bike_sensor_monitor.sv
// Testbench for bike_sensor_monitor: vector table, directed corner-case
// sequences and randomized stimulus against a behavioural model.

module tb_bike_sensor_monitor;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int CH = 4;
  localparam int T  = 10;
  localparam int TD = 3;
`ifdef BUZZER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ack;
  logic [N-1:0] btn_in;
  logic [N-1:0] leds;
  logic [N-1:0] rise;
  logic         alarm;
  logic         buz;

  bike_sensor_monitor #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .ALARM_CH(CH),
    .ALARM_TIMEOUT(T), .TONE_DIV(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .ack(ack),
    .BOARD_LEDs(leds), .rise_pulse(rise), .alarm_active(alarm), .BUZZER(buz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounced level flips once the last D synchronised samples all differ
  // from it; alarm fires once the seat has been seen empty for T+1 edges
  // after having been seen occupied, unless acknowledged meanwhile.
  logic [N-1:0] btnq[$];
  logic [N-1:0] syncq[$];
  logic [N-1:0] m_stable, m_stable_old, m_rise;
  int           m_zeros;
  bit           m_armed, m_alarm, m_buz;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] sync_now, st_pre;
    bit seat, alarm_pre, all_diff;
    int age;
    if (!rst_n) begin
      btnq.delete();
      syncq.delete();
      btnq.push_back('0);
      btnq.push_back('0);
      for (int j = 0; j < D; j++) syncq.push_back('0);
      m_stable = '0; m_stable_old = '0; m_rise = '0;
      m_zeros = 0; m_armed = 0; m_alarm = 0; m_buz = 0;
    end else begin
      sync_now = btnq[btnq.size()-2];
      btnq.push_back(btn_in);
      if (btnq.size() > 4) void'(btnq.pop_front());
      syncq.push_back(sync_now);
      if (syncq.size() > D + 2) void'(syncq.pop_front());
      st_pre       = m_stable;
      m_rise       = m_stable & ~m_stable_old;
      m_stable_old = m_stable;
      for (int i = 0; i < N; i++) begin
        all_diff = 1;
        for (int j = 0; j < D; j++)
          if (syncq[syncq.size()-1-j][i] == st_pre[i]) all_diff = 0;
        if (all_diff) m_stable[i] = ~st_pre[i];
      end
      seat      = st_pre[CH];
      alarm_pre = m_alarm;
      if (seat) begin
        m_armed = 1;
        m_zeros = 0;
      end else begin
        if (m_zeros < 1000000) m_zeros++;
        if (alarm_pre && ack) m_armed = 0;
      end
      m_alarm = m_armed && !seat && (m_zeros >= T + 1);
      age     = m_zeros - (T + 1);
      if (PWM) m_buz = m_alarm && (((age / TD) % 2) == 1);
      else     m_buz = m_alarm;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_n  = 1'b0;
    btn_in = '0;
    ack    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_led(input int ch, input logic val, input string name);
    int n = 0;
    while (leds[ch] !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (leds[ch] !== val) chk(name, 32'(leds[ch]), 32'(val));
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic         ack;
    int           hold;
    logic [N-1:0] leds;
    logic         alarm;
    logic         buz_pwm;
    logic         buz_plain;
  } vec_t;

  vec_t vecs[12];
  int   hold[N];
  logic [6:0] tone_pat;

  initial begin
    vecs[0]  = '{5'b00001, 1'b0, 3,  5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00000, 1'b0, 5,  5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'b00010, 1'b0, 6,  5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b10010, 1'b0, 8,  5'b10010, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b00010, 1'b0, 6,  5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b00010, 1'b0, 10, 5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'b00010, 1'b0, 1,  5'b00010, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{5'b00010, 1'b0, 3,  5'b00010, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{5'b00010, 1'b0, 3,  5'b00010, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{5'b00010, 1'b1, 1,  5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'b00010, 1'b0, 20, 5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'b10010, 1'b0, 7,  5'b10010, 1'b0, 1'b0, 1'b0};
    tone_pat = 7'b0111000;

    // Reset state
    rst_n = 1'b0; btn_in = '0; ack = 1'b0;
    #1;
    chk("reset_leds", 32'(leds), 32'(0));
    chk("reset_rise", 32'(rise), 32'(0));
    chk("reset_alarm", 32'(alarm), 32'(0));
    chk("reset_buzzer", 32'(buz), 32'(0));
    do_reset();

    // Vector table
    for (int i = 0; i < 12; i++) begin
      btn_in = vecs[i].btn;
      ack    = vecs[i].ack;
      repeat (vecs[i].hold) @(negedge clk);
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].leds));
      chk($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].alarm));
      chk($sformatf("vec%0d_buzzer", i), 32'(buz),
          32'(PWM ? vecs[i].buz_pwm : vecs[i].buz_plain));
    end

    // Bounce rejection on ch0 alongside a clean press on ch1
    do_reset();
    btn_in[0] = 1'b1;
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("bounce_led0", 32'(leds[0]), 32'(0));
      chk("bounce_rise0", 32'(rise[0]), 32'(0));
      chk("press_led1", 32'(leds[1]), 32'(k >= 6));
      chk("press_rise1", 32'(rise[1]), 32'(k == 7));
      if (k == 3) btn_in[0] = 1'b0;
    end

    // Alarm timing and buzzer waveform
    btn_in[CH] = 1'b1;
    wait_led(CH, 1'b1, "seat_up_timeout");
    repeat (2) @(negedge clk);
    btn_in[CH] = 1'b0;
    wait_led(CH, 1'b0, "seat_down_timeout");
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("alarm_timing", 32'(alarm), 32'(k == 11));
    end
    for (int a = 0; a < 7; a++) begin
      if (a > 0) @(negedge clk);
      chk("buzzer_wave", 32'(buz), 32'(PWM ? tone_pat[a] : 1'b1));
    end

    // Seat returns with ack in the same cycle: seat wins, FSM re-arms
    btn_in[CH] = 1'b1;
    wait_led(CH, 1'b1, "seat_back_timeout");
    chk("alarm_before_seat", 32'(alarm), 32'(1));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("seat_ack_alarm", 32'(alarm), 32'(0));
    btn_in[CH] = 1'b0;
    wait_led(CH, 1'b0, "seat_down2_timeout");
    repeat (11) @(negedge clk);
    chk("rearm_alarm", 32'(alarm), 32'(1));

    // Acknowledge silences until the seat is re-occupied
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_clears_alarm", 32'(alarm), 32'(0));
    chk("ack_clears_buzzer", 32'(buz), 32'(0));
    repeat (20) begin
      @(negedge clk);
      chk("silenced", 32'(alarm), 32'(0));
    end
    btn_in[CH] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[CH] = 1'b0;
    repeat (25) begin
      @(negedge clk);
      chk("seat_glitch_alarm", 32'(alarm), 32'(0));
      chk("seat_glitch_led", 32'(leds[CH]), 32'(0));
    end

    // Cancel: seat re-occupied partway through the countdown
    btn_in[CH] = 1'b1;
    wait_led(CH, 1'b1, "seat_up3_timeout");
    repeat (2) @(negedge clk);
    btn_in[CH] = 1'b0;
    wait_led(CH, 1'b0, "seat_down3_timeout");
    btn_in[CH] = 1'b1;
    repeat (25) begin
      @(negedge clk);
      chk("cancel_alarm", 32'(alarm), 32'(0));
    end
    chk("cancel_seat_led", 32'(leds[CH]), 32'(1));

    // Asynchronous reset during ALARM
    btn_in[CH] = 1'b0;
    wait_led(CH, 1'b0, "seat_down4_timeout");
    repeat (11) @(negedge clk);
    chk("pre_reset_alarm", 32'(alarm), 32'(1));
    chk("pre_reset_leds", 32'(leds), 32'(5'b00010));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_alarm", 32'(alarm), 32'(0));
    chk("async_rst_buzzer", 32'(buz), 32'(0));
    chk("async_rst_leds", 32'(leds), 32'(0));
    @(negedge clk);
    btn_in = 5'b10010;
    rst_n  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("post_rst_leds", 32'(leds), 32'(k >= 6 ? 5'b10010 : 5'b00000));
      chk("post_rst_alarm", 32'(alarm), 32'(0));
    end

    // Randomized stimulus against the model
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rand_leds", 32'(leds), 32'(m_stable));
      chk("rand_rise", 32'(rise), 32'(m_rise));
      chk("rand_alarm", 32'(alarm), 32'(m_alarm));
      chk("rand_buzzer", 32'(buz), 32'(m_buz));
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = 1'($urandom_range(0, 1));
          hold[i]   = (i == CH) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 9));
        end else begin
          hold[i]--;
        end
      end
      ack = ($urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bike_sensor_monitor.md
# bike_sensor_monitor

Parametrised successor to the handlebar/seat button block. Synchronises and debounces `N_CH` contact inputs and drives one LED per channel from the debounced level. Emits one-cycle rising-edge pulses per channel. Runs a seat-absence alarm on a designated channel that drives the buzzer after a programmable timeout. Sits between the board push-button/contact pins and the LED/buzzer pins.

## Interface
- `N_CH`, 5, number of input channels (≥1)
- `DEBOUNCE_CYCLES`, 250000, consecutive cycles a new synchronised level must hold before acceptance (≥1)
- `ALARM_CH`, 4, index of the seat channel feeding the alarm (0..N_CH-1)
- `ALARM_TIMEOUT`, 50000000, cycles of continuous seat release before alarm (≥1)
- `TONE_DIV`, 12500, buzzer half-period in cycles when PWM tone is enabled (≥1)
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_in`  in  N_CH  raw asynchronous contact inputs, 1 = pressed/occupied
- `ack`  in  1  synchronous alarm acknowledge (level, sampled each cycle)
- `BOARD_LEDs`  out  N_CH  debounced level per channel
- `rise_pulse`  out  N_CH  one-cycle pulse on debounced 0→1 per channel
- `alarm_active`  out  1  high while FSM in ALARM
- `BUZZER`  out  1  buzzer drive

## Operation
- Per channel: 2-flop synchroniser → debounce counter → `stable` register. `BOARD_LEDs = stable`.
- Debounce: if sync ≠ stable, counter increments; when counter reaches DEBOUNCE_CYCLES-1 and sync still differs, `stable` ← sync and counter clears. Any cycle with sync = stable clears counter (glitch shorter than DEBOUNCE_CYCLES is rejected).
- Counter widths: $clog2(param+1); no wrap possible since counter clears at terminal value.
- `rise_pulse[i]` = stable[i] & ~stable_d[i], registered; exactly one cycle per accepted rising edge.
- Alarm FSM on `stable[ALARM_CH]` (seat):
  - IDLE (reset): seat=1 → ARMED.
  - ARMED: seat=0 → COUNT, timer ← 0.
  - COUNT: timer +1 per cycle; seat=1 → ARMED; timer = ALARM_TIMEOUT-1 → ALARM.
  - ALARM: seat=1 → ARMED; else ack=1 → IDLE (silenced until seat re-occupied).
- Simultaneous seat=1 and ack in ALARM → ARMED (seat wins).
- ack outside ALARM ignored.
- Channels other than ALARM_CH never affect the FSM.

## Timing
- Reset values: sync flops, stable, counters, `BOARD_LEDs`, `rise_pulse`, `alarm_active`, `BUZZER`, timer all 0; FSM IDLE; tone phase 0.
- Input-to-LED latency: 2 cycles (sync) + DEBOUNCE_CYCLES cycles.
- `rise_pulse` asserts 1 cycle after the `BOARD_LEDs` rising edge.
- Seat debounced fall → `alarm_active` high after exactly ALARM_TIMEOUT+1 cycles (1 to enter COUNT, ALARM_TIMEOUT in COUNT).
- `alarm_active` deasserts the cycle after exiting ALARM; `BUZZER` is 0 in the same cycle.
- `rst_n` low mid-debounce or mid-alarm: all state clears immediately (async); after release, inputs held high re-debounce from zero.

## Configuration
- `BUZZER_PWM_EN` defined: in ALARM, `BUZZER` is a square wave toggling every TONE_DIV cycles (period 2·TONE_DIV). Starts at 0 on the ALARM entry cycle; first rise after TONE_DIV cycles. Tone divider is held at 0 outside ALARM.
- Not defined: `BUZZER = alarm_active`; TONE_DIV unused, no divider logic.

## Test plan
(DEBOUNCE_CYCLES=4, ALARM_TIMEOUT=10, TONE_DIV=3, N_CH=5, ALARM_CH=4)
- Bounce rejection: btn_in[0] pulses high 3 cycles then low → BOARD_LEDs[0] stays 0, rise_pulse[0] never asserts.
- Clean press: btn_in[1] held high → BOARD_LEDs[1]=1 exactly 6 cycles after the change is applied; rise_pulse[1] high for 1 cycle, one cycle later.
- Alarm: seat debounced high then btn_in[4] released and held → alarm_active=1 exactly 11 cycles after BOARD_LEDs[4] falls; with BUZZER_PWM_EN, BUZZER reads 0,0,0,1,1,1,0… from entry; without it, BUZZER=1.
- Cancel/ack: seat re-pressed at COUNT timer=5 → no alarm. In ALARM, ack=1 → alarm_active=0 next cycle, and a new release without re-occupying the seat raises no alarm. Seat=1 with ack in the same cycle → ARMED.
- Reset mid-alarm: rst_n low during ALARM → BUZZER, alarm_active, BOARD_LEDs all 0 asynchronously; FSM IDLE after release.
